// File: rtl/ghost_pkg.sv
// Shared ghost definitions: schedule phase encoding, default phase durations
// and the movement direction encoding used by the ghost AI blocks.
package ghost_pkg;

  typedef enum logic [2:0] {
    PH_SCATTER0      = 3'd0,
    PH_CHASE0        = 3'd1,
    PH_SCATTER1      = 3'd2,
    PH_CHASE1        = 3'd3,
    PH_SCATTER2      = 3'd4,
    PH_CHASE2        = 3'd5,
    PH_SCATTER3      = 3'd6,
    PH_CHASE_FOREVER = 3'd7
  } phase_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int DEF_SCATTER_LONG_S  = 7;
  localparam int DEF_SCATTER_SHORT_S = 5;
  localparam int DEF_CHASE_S         = 20;

  // Terminal chase phase has no duration; it only leaves on restart/reset.
  function automatic logic [4:0] phase_duration(input phase_t ph, input int scatter_long,
                                                input int scatter_short, input int chase);
    logic [4:0] dur;
    dur = 5'd1;
    case (ph)
      PH_SCATTER0, PH_SCATTER1:         dur = 5'(scatter_long);
      PH_SCATTER2, PH_SCATTER3:         dur = 5'(scatter_short);
      PH_CHASE0, PH_CHASE1, PH_CHASE2:  dur = 5'(chase);
      default:                          dur = 5'd1;
    endcase
    return dur;
  endfunction

endpackage

// File: rtl/ghost_sec_prescaler.sv
// Divides the system clock into one-second ticks; holds its partial count
// whenever counting is paused so no fraction of a second is lost.
module ghost_sec_prescaler
  import ghost_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic secTick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [W-1:0] count;
  logic         at_last;

  assign at_last = (count == W'(CLK_HZ - 1));
  assign secTick = run & at_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      count <= at_last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/ghost_mode_timer.sv
// Global scatter/chase schedule for the ghost AIs: walks the 8-phase arcade
// timetable in seconds, pausing while frozen, and pulses modeChange on each advance.
module ghost_mode_timer
  import ghost_pkg::*;
#(
  parameter int CLK_HZ          = 25_000_000,
  parameter int SCATTER_LONG_S  = DEF_SCATTER_LONG_S,
  parameter int SCATTER_SHORT_S = DEF_SCATTER_SHORT_S,
  parameter int CHASE_S         = DEF_CHASE_S
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       freeze,
  input  logic       restart,
  output logic       isScatter,
  output logic       isChase,
  output logic [2:0] phase,
  output logic       modeChange
);

  if (SCATTER_LONG_S < 1 || SCATTER_LONG_S > 31 ||
      SCATTER_SHORT_S < 1 || SCATTER_SHORT_S > 31 ||
      CHASE_S < 1 || CHASE_S > 31) begin : g_bad_duration
    $error("ghost_mode_timer: phase durations must be within 1..31 seconds");
  end

  phase_t     state;
  phase_t     next_state;
  logic [4:0] sec_count;
  logic [4:0] dur;
  logic       run;
  logic       terminal;
  logic       sec_tick;

  assign terminal   = (state == PH_CHASE_FOREVER);
  assign run        = enable & ~freeze & ~terminal;
  assign dur        = phase_duration(state, SCATTER_LONG_S, SCATTER_SHORT_S, CHASE_S);
  assign next_state = phase_t'(state + 3'd1);
  assign phase      = state;

  ghost_sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart | terminal),
    .run    (run),
    .secTick(sec_tick)
  );

  // Restart shares the reset path so it also beats a coincident phase advance.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state      <= PH_SCATTER0;
      sec_count  <= 5'd0;
      isScatter  <= 1'b1;
      isChase    <= 1'b0;
      modeChange <= 1'b0;
    end else begin
      modeChange <= 1'b0;
      if (sec_tick) begin
        if (sec_count == dur - 5'd1) begin
          state      <= next_state;
          sec_count  <= 5'd0;
          isScatter  <= ~next_state[0];
          isChase    <= next_state[0];
          modeChange <= 1'b1;
        end else begin
          sec_count <= sec_count + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ghost_mode_timer.sv
// Directed bench for ghost_mode_timer at CLK_HZ=10: a vector table walking the
// schedule plus hand sequences for freeze, full run, restart and reset corners.
module tb_ghost_mode_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       freeze;
  logic       restart;
  logic       isScatter;
  logic       isChase;
  logic [2:0] phase;
  logic       modeChange;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       frz;
    logic       rs;
    int         cycles;
    logic [2:0] ph;
    logic       sc;
    logic       ch;
    logic       mc;
  } vec_t;

  vec_t vecs[14];

  ghost_mode_timer #(
    .CLK_HZ(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .freeze    (freeze),
    .restart   (restart),
    .isScatter (isScatter),
    .isChase   (isChase),
    .phase     (phase),
    .modeChange(modeChange)
  );

  always #5 clk = ~clk;

  // Advance n clock edges, sampling 1 time unit after each edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (modeChange) pulses++;
    end
  endtask

  task automatic check_output(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got {phase,sc,ch,mc}=%b_%b_%b_%b expected %b_%b_%b_%b",
               name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] ph, input logic sc,
                             input logic ch, input logic mc);
    check_output(name, {phase, isScatter, isChase, modeChange}, {ph, sc, ch, mc});
  endtask

  task automatic check_count(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic en, input logic frz, input logic rs);
    reset   = rst;
    enable  = en;
    freeze  = frz;
    restart = rs;
  endtask

  task automatic do_reset(input logic en);
    apply_stimulus(1'b1, en, 1'b0, 1'b0);
    step(2);
    reset  = 1'b0;
    pulses = 0;
  endtask

  initial begin
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

    //           rst   en    frz   rs   cycles ph    sc    ch    mc
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0,   2, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0,  69, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 3'd1, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 198, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 500, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 100, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0,  69, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 3'd3, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0,  37, 3'd3, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1,   1, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0,  69, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 3'd1, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].en, vecs[i].frz, vecs[i].rs);
      step(vecs[i].cycles);
      check_state($sformatf("vec%0d", i), vecs[i].ph, vecs[i].sc, vecs[i].ch, vecs[i].mc);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Freeze for 30 cycles in the middle of phase 0 pushes the advance to cycle 100.
    do_reset(1'b1);
    step(35);
    freeze = 1'b1;
    step(30);
    freeze = 1'b0;
    step(34);
    check_state("freeze_c99", 3'd0, 1'b1, 1'b0, 1'b0);
    step(1);
    check_state("freeze_c100", 3'd1, 1'b0, 1'b1, 1'b1);

    // Full schedule: phase 7 at cycle 840 after exactly seven pulses, then parked.
    do_reset(1'b1);
    step(839);
    check_state("full_c839", 3'd6, 1'b1, 1'b0, 1'b0);
    step(1);
    check_state("full_c840", 3'd7, 1'b0, 1'b1, 1'b1);
    check_count("full_pulses", pulses, 7);
    step(2000);
    check_state("full_parked", 3'd7, 1'b0, 1'b1, 1'b0);
    check_count("full_pulses_after", pulses, 7);

    // Restart on the very cycle phase 3 would advance to phase 4.
    do_reset(1'b1);
    step(539);
    check_state("rs_pre", 3'd3, 1'b0, 1'b1, 1'b0);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check_state("rs_edge", 3'd0, 1'b1, 1'b0, 1'b0);
    step(69);
    check_state("rs_c69", 3'd0, 1'b1, 1'b0, 1'b0);
    step(1);
    check_state("rs_c70", 3'd1, 1'b0, 1'b1, 1'b1);

    // Enable low straight after reset keeps everything at phase 0.
    do_reset(1'b0);
    step(500);
    check_state("en_low", 3'd0, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    step(69);
    check_state("en_c69", 3'd0, 1'b1, 1'b0, 1'b0);
    step(1);
    check_state("en_c70", 3'd1, 1'b0, 1'b1, 1'b1);

    // Reset together with restart in the middle of phase 5.
    do_reset(1'b1);
    step(650);
    check_state("rst_pre", 3'd5, 1'b0, 1'b1, 1'b0);
    reset   = 1'b1;
    restart = 1'b1;
    step(1);
    check_state("rst_edge", 3'd0, 1'b1, 1'b0, 1'b0);
    reset   = 1'b0;
    restart = 1'b0;
    step(70);
    check_state("rst_after", 3'd1, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
